// File: rtl/nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_ctrl
//
// Purpose:
//   Wide adder built from a single 4-bit adder that is reused over time.
//   One nibble is added per clock, least significant nibble first.
//   The carry between nibbles is held in a register.
//   Operands are accepted with a ready/start handshake.
//   Completion is flagged by a one-cycle done pulse.
//   Result: {carry_out, sum_out} = a + b + c_in.
//
// Ports:
//   clk_in     clock, rising edge
//   rst_in     synchronous reset, active-high
//   start_in   start request, only honoured while ready_out=1
//   a_in       augend, WIDTH bits, captured on the accepting edge
//   b_in       addend, WIDTH bits, captured on the accepting edge
//   c_in       carry input, captured on the accepting edge
//   ready_out  block can accept start_in this cycle (IDLE or DONE)
//   busy_out   addition in progress (ADD)
//   done_out   one-cycle pulse; sum_out/carry_out were just updated
//   sum_out    result of the last completed addition
//   carry_out  carry-out of the last completed addition
//
// The file also holds full_adder_4, the shared 4-bit adder slice.
// ---------------------------------------------------------------------------

// 4-bit ripple adder slice with carry in and carry out.
module full_adder_4 (
  input  logic [3:0] a_in,
  input  logic [3:0] b_in,
  input  logic       c_in,
  output logic [3:0] sum_out,
  output logic       carry_out
);

  // Widen every operand to 5 bits so that the carry lands in the top bit.
  assign {carry_out, sum_out} = {1'b0, a_in} + {1'b0, b_in} + {4'b0000, c_in};

endmodule

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             ready_out,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST_NIB = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADD  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] work_reg;
  logic [WIDTH-1:0] work_next;
  logic [CW-1:0]    nib_q;
  logic             carry_q;
  logic [3:0]       fa_a;
  logic [3:0]       fa_b;
  logic [3:0]       fa_sum;
  logic             fa_co;
  logic             accept;
  logic             last_nib;

  // Handshake status is a pure decode of the state register.
  // Because of this, ready and busy can never both be high.
  assign ready_out = (state_q != ADD);
  assign busy_out  = (state_q == ADD);
  assign done_out  = (state_q == DONE);

  assign accept   = start_in & ready_out;
  assign last_nib = (nib_q == LAST_NIB);

  // The counter selects the nibble that feeds the shared adder.
  // Carry-in always comes from carry_q.
  // carry_q is loaded with c_in at acceptance, so nibble 0 sees c_in.
  assign fa_a = a_reg[nib_q*4 +: 4];
  assign fa_b = b_reg[nib_q*4 +: 4];

  full_adder_4 u_fa (
    .a_in      (fa_a),
    .b_in      (fa_b),
    .c_in      (carry_q),
    .sum_out   (fa_sum),
    .carry_out (fa_co)
  );

  // Working result with the current nibble merged in.
  // On the last nibble this is the complete sum.
  always_comb begin
    work_next = work_reg;
    work_next[nib_q*4 +: 4] = fa_sum;
  end

  // Next-state logic.
  // DONE lasts exactly one cycle.
  // A start seen in DONE chains straight into another addition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_in) state_d = ADD;
      ADD:     if (last_nib) state_d = DONE;
      DONE:    state_d = start_in ? ADD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  // Reset aborts any addition in flight, so it never produces a done pulse.
  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath.
  // Operands are copied on acceptance, so the inputs may change afterwards.
  // The published result only changes on the edge that enters DONE.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      a_reg     <= '0;
      b_reg     <= '0;
      work_reg  <= '0;
      nib_q     <= '0;
      carry_q   <= 1'b0;
      sum_out   <= '0;
      carry_out <= 1'b0;
    end else if (accept) begin
      a_reg    <= a_in;
      b_reg    <= b_in;
      work_reg <= '0;
      nib_q    <= '0;
      carry_q  <= c_in;
    end else if (state_q == ADD) begin
      work_reg <= work_next;
      carry_q  <= fa_co;
      nib_q    <= nib_q + 1'b1;
      if (last_nib) begin
        sum_out   <= work_next;
        carry_out <= fa_co;
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_adder_ctrl
//
// Purpose:
//   Self-checking bench for nibble_serial_adder_ctrl with WIDTH=16.
//   Single additions come from a table of directed vectors.
//   Back-to-back, busy-ignore and mid-operation reset are hand-written
//   sequences.
//   Outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_nibble_serial_adder_ctrl;

  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             ready_out;
  logic             busy_out;
  logic             done_out;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic [WIDTH-1:0] sum;
    logic             co;
  } vec_t;

  vec_t vecs[8];

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk_in    (clk),
    .rst_in    (rst),
    .start_in  (start),
    .a_in      (a_in),
    .b_in      (b_in),
    .c_in      (c_in),
    .ready_out (ready_out),
    .busy_out  (busy_out),
    .done_out  (done_out),
    .sum_out   (sum_out),
    .carry_out (carry_out)
  );

  // Free-running clock with a 10-time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one value and keeps the running counts.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits for ready and presents one operand set with a start pulse.
  // Returns 1 time unit after the accepting edge.
  // The inputs are then scrambled to show that they were captured.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready_out && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready_out) checkOutput("ready_wait_timeout", 32'(ready_out), 32'd1);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    c_in  = c;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in  = ~a;
    b_in  = ~b;
    c_in  = ~c;
  endtask

  // Runs one addition and checks the result.
  // Also checks the latency, the busy duration and the handshake decode.
  task automatic runAdd(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic c, input logic [WIDTH-1:0] exp_sum, input logic exp_co);
    int busy_cnt;
    int lat;
    busy_cnt = 0;
    lat      = 0;
    applyStimulus(a, b, c);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done_out) begin
        lat = n;
        break;
      end
      if (busy_out) begin
        busy_cnt++;
        checkOutput({name, "_ready_in_add"}, 32'(ready_out), 32'd0);
      end
    end
    checkOutput({name, "_done_latency"}, 32'(lat), 32'(NIBBLES + 1));
    checkOutput({name, "_busy_cycles"}, 32'(busy_cnt), 32'(NIBBLES));
    checkOutput({name, "_sum"}, 32'(sum_out), 32'(exp_sum));
    checkOutput({name, "_carry"}, 32'(carry_out), 32'(exp_co));
    checkOutput({name, "_ready_in_done"}, 32'(ready_out), 32'd1);
  endtask

  initial begin
    int d1;
    int d2;
    int dones;

    // Each sum below was computed by hand.
    vecs[0] = '{"basic",     16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0};
    vecs[1] = '{"ripple_b1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{"ripple_c1", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[3] = '{"small",     16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0};
    vecs[4] = '{"top_ovf",   16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{"mixed",     16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0};
    vecs[6] = '{"max_nocry", 16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0};
    vecs[7] = '{"alt_wrap",  16'hF0F0, 16'h0F0F, 1'b1, 16'h0000, 1'b1};

    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    c_in  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", 32'(ready_out), 32'd1);
    checkOutput("rst_busy",  32'(busy_out),  32'd0);
    checkOutput("rst_done",  32'(done_out),  32'd0);
    checkOutput("rst_sum",   32'(sum_out),   32'd0);
    checkOutput("rst_carry", 32'(carry_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_ready", 32'(ready_out), 32'd1);
    checkOutput("idle_done",  32'(done_out),  32'd0);

    for (int i = 0; i < 8; i++)
      runAdd(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].sum, vecs[i].co);

    // Back-to-back: start is held high across DONE.
    // The second operand set is staged while the first one is still adding.
    repeat (2) @(negedge clk);
    start = 1'b1;
    a_in  = 16'h0001;
    b_in  = 16'h0001;
    c_in  = 1'b0;
    @(posedge clk);
    #1;
    d1 = 0;
    d2 = 0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (n == 1) begin
        a_in = 16'h8000;
        b_in = 16'h8000;
      end
      if (done_out && d1 == 0) begin
        d1 = n;
        checkOutput("b2b_sum1",   32'(sum_out),   32'h0002);
        checkOutput("b2b_carry1", 32'(carry_out), 32'd0);
      end else if (done_out) begin
        d2 = n;
        start = 1'b0;
        checkOutput("b2b_sum2",   32'(sum_out),   32'h0000);
        checkOutput("b2b_carry2", 32'(carry_out), 32'd1);
        break;
      end else if (d1 != 0) begin
        checkOutput("b2b_sum_stable", 32'(sum_out), 32'h0002);
      end
    end
    start = 1'b0;
    checkOutput("b2b_first_done", 32'(d1), 32'(NIBBLES + 1));
    checkOutput("b2b_gap", 32'(d2 - d1), 32'(NIBBLES + 1));

    // Busy ignore: a start pulse during ADD must not queue a second addition.
    repeat (2) @(negedge clk);
    applyStimulus(16'h0003, 16'h0004, 1'b0);
    dones = 0;
    d1    = 0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (n == 2) begin
        start = 1'b1;
        a_in  = 16'hAAAA;
      end
      if (n == 3) start = 1'b0;
      if (busy_out) checkOutput("ign_ready_in_add", 32'(ready_out), 32'd0);
      if (done_out) begin
        dones++;
        if (d1 == 0) begin
          d1 = n;
          checkOutput("ign_sum", 32'(sum_out), 32'h0007);
        end
      end
    end
    checkOutput("ign_done_count", 32'(dones), 32'd1);
    checkOutput("ign_done_at", 32'(d1), 32'(NIBBLES + 1));

    // Reset during the second ADD cycle aborts the addition silently.
    applyStimulus(16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid_rst_ready", 32'(ready_out), 32'd1);
    checkOutput("mid_rst_busy",  32'(busy_out),  32'd0);
    checkOutput("mid_rst_done",  32'(done_out),  32'd0);
    checkOutput("mid_rst_sum",   32'(sum_out),   32'd0);
    checkOutput("mid_rst_carry", 32'(carry_out), 32'd0);
    dones = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (done_out) dones++;
    end
    checkOutput("mid_rst_no_done", 32'(dones), 32'd0);
    runAdd("after_rst", 16'h0005, 16'h0006, 1'b0, 16'h000B, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
Sequencer that performs WIDTH-bit additions by time-multiplexing one internal full_adder_4 instance, one 4-bit nibble per clock, LSB nibble first. The carry is registered between nibbles. Operands are accepted with a ready/start handshake and the result is flagged with a one-cycle done pulse. Serves as the area-cheap wide adder for datapaths that tolerate multi-cycle latency.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8
NIBBLES, WIDTH/4, derived nibble count (localparam, not overridable)

Ports:
clk_in  input  1  clock, rising edge
rst_in  input  1  synchronous reset, active-high
start_in  input  1  request to start an addition; sampled only when ready_out=1
a_in  input  WIDTH  augend, captured on the accepting edge
b_in  input  WIDTH  addend, captured on the accepting edge
c_in  input  1  carry input, captured on the accepting edge
ready_out  output  1  block can accept start_in this cycle
busy_out  output  1  addition in progress (state ADD)
done_out  output  1  one-cycle pulse: sum_out/carry_out just updated
sum_out  output  WIDTH  result of the last completed addition
carry_out  output  1  carry-out of the last completed addition

Behaviour:
- Reset (rst_in high at an edge), synchronous, overrides everything including mid-operation: state=IDLE, nibble counter=0, carry reg=0, sum_out=0, carry_out=0, done_out=0; ready_out=1, busy_out=0. Any operation in flight is discarded and no done_out is produced for it.
- State IDLE: ready_out=1, busy_out=0, done_out=0. start_in=1 at an edge -> capture a_in, b_in and c_in; nibble counter=0; go to ADD.
- State ADD: ready_out=0, busy_out=1. Adder inputs are nibble k of the captured a and b, with carry-in = carry reg (c_in for k=0).
- On each edge in ADD: store the adder sum into nibble k of a working register; carry reg <= adder carry; k <= k+1.
- When k=NIBBLES-1 at the edge, copy the full working result into sum_out and the final carry into carry_out, then go to DONE.
- start_in during ADD is ignored; it is not queued.
- State DONE, exactly one cycle: done_out=1, ready_out=1, busy_out=0.
  - start_in=1 -> accept new operands and go to ADD (back-to-back operation).
  - Otherwise go to IDLE.
- Latency: operands accepted at edge E -> done_out high in the cycle after edge E+NIBBLES. Maximum throughput is one addition per NIBBLES+1 cycles.
- sum_out and carry_out change only on the edge entering DONE (or on reset). They hold stable through IDLE and through the next ADD until the next completion.
- Arithmetic: {carry_out, sum_out} = a + b + c_in, modulo 2^(WIDTH+1). Wrap-around is reported only via carry_out; there is no overflow/sign flag.
- Inputs a_in, b_in and c_in may change freely after the accepting edge without affecting the result.
- ready_out and busy_out are decoded from state. done_out is a state decode (DONE).
- ready_out and busy_out are never both 1. done_out=1 implies ready_out=1.

Test Plan:
- Basic add, WIDTH=16: a=0x1234, b=0x0FFF, c_in=0, start pulse -> done_out exactly 4 cycles after acceptance edge, sum_out=0x2233, carry_out=0. busy_out high for exactly 4 cycles.
- Full carry ripple across nibbles: a=0xFFFF, b=0x0001, c_in=0 -> sum_out=0x0000, carry_out=1. Then a=0xFFFF, b=0x0000, c_in=1 -> sum_out=0x0000, carry_out=1.
- Back-to-back: hold start_in=1 continuously with a=0x0001,b=0x0001 then a=0x8000,b=0x8000 -> done pulses 5 cycles apart. Results in order: 0x0002/carry 0, then 0x0000/carry 1. sum_out stable between the pulses.
- Busy ignore: start_in pulsed with a=0xAAAA during ADD of 0x0003+0x0004 -> result 0x0007; no second done_out; ready_out=0 throughout ADD.
- Reset mid-operation: assert rst_in in the 2nd ADD cycle of 0x1111+0x2222 -> next cycle shows ready_out=1, busy_out=0, sum_out=0, carry_out=0; no done_out ever for that operation. A subsequent 0x0005+0x0006 returns 0x000B.
- Reset values: after rst_in with no start -> ready_out=1, busy_out=0, done_out=0, sum_out=0, carry_out=0.
